io_trace_checker: RTL
=====================

// Module: io_trace_checker
// PURPOSE
//  Self-checking monitor for the TTL CPU sim/FPGA build.
//  Watches NUM_CH output channels (o_output, o_ioAddress, ...) and detects every value change.
//  Compares each change, in order, against a loadable expected-trace table.
//  Reports pass/fail with diagnostics, replacing hand-written per-edge assertion chains.
// PARAMETERS
//  DATA_W      8     width of one observed channel
//  NUM_CH      2     number of observed channels
//  DEPTH       128   expected-trace entries
//  TIMEOUT_CYC 4096  max oszClk cycles between matches (TRACE_TIMEOUT_EN only)
// PORTS
//  oszClk         in   1                system clock
//  resetn         in   1                reset: asynchronous, active-high
//  i_start        in   1                pulse: arm checker (IDLE only)
//  i_obsValid     in   1                observation qualifier; changes ignored while 0
//  i_obs          in   NUM_CH*DATA_W    observed channels, ch c = [c*DATA_W +: DATA_W]
//  i_tblWe        in   1                table write strobe
//  i_tblAddr      in   $clog2(DEPTH)    table write address
//  i_tblData      in   CH_W+DATA_W      {channel, expected value}; CH_W=$clog2(NUM_CH) min 1
//  i_tblLen       in   $clog2(DEPTH)+1  entries in trace, sampled on i_start
//  o_busy         out  1                ARM or RUN
//  o_pass         out  1                trace completed, sticky until next i_start
//  o_fail         out  1                failure, sticky until next i_start
//  o_failCode     out  fail_code_e      reason
//  o_failIndex    out  $clog2(DEPTH)+1  entry index at failure
//  o_failActual   out  CH_W+DATA_W      {ch, value} that failed
//  o_matchCount   out  $clog2(DEPTH)+1  entries matched so far
// BEHAVIOUR
//  Reset
//   - All outputs 0, o_failCode=FC_NONE, state IDLE.
//   - Table contents undefined.
//   - resetn mid-RUN aborts immediately to IDLE; no pass/fail is reported.
//  Table
//   - Written only in IDLE; i_tblWe in other states is ignored.
//   - Read combinationally at the entry pointer.
//  States
//   - IDLE -> ARM on i_start; latch i_tblLen, clear flags, counters and pointer.
//   - ARM (1 cycle): snapshot i_obs into prev regs. If len==0 go to PASS, else go to RUN.
//   - RUN: on each cycle with i_obsValid=1, every channel whose value differs from prev
//     sets its bit in pend[NUM_CH]; prev is updated.
//   - RUN: one pending channel is serviced per cycle, lowest index first.
//     Its value is the one captured with pend.
//   - Compare: entry.ch!=c -> FAIL/FC_WRONG_CH; value mismatch -> FAIL/FC_MISMATCH.
//     Otherwise the pointer and o_matchCount increment.
//     On the match with pointer==len-1 go to PASS.
//   - Change on a channel whose pend bit is set and not being serviced that cycle
//     -> FAIL/FC_OVERRUN.
//   - PASS/FAIL are terminal until i_start; further changes are ignored.
//   - i_start in RUN is ignored.
//  Latency
//   - A change sampled at edge k with an empty queue is compared at edge k+1.
//   - o_pass/o_fail assert after edge k+1.
//  Simultaneous changes
//   - Changes on ch0 and ch1 at the same edge are checked against entries n and n+1,
//     on consecutive cycles.
//  Diagnostics
//   - o_failIndex, o_failActual and o_failCode are captured in the failing cycle and held.
// CONFIGURATION
//  TRACE_TIMEOUT_EN defined
//   - Counter cleared at ARM and on every match.
//   - Reaching TIMEOUT_CYC in RUN -> FAIL/FC_TIMEOUT, with o_failActual=0.
//  TRACE_TIMEOUT_EN undefined
//   - No counter; FC_TIMEOUT is never produced.
//   - RUN may wait indefinitely.
// STRUCTURE
//  io_trace_pkg
//   - typedef enum logic[2:0] fail_code_e:
//     FC_NONE, FC_MISMATCH, FC_WRONG_CH, FC_OVERRUN, FC_TIMEOUT.
//   - typedef enum state_e: IDLE, ARM, RUN, PASS, FAIL.
//   - function ch_w(NUM_CH).
//  io_trace_table
//   - Sub-module: DEPTH x (CH_W+DATA_W) RAM, sync write, async read.
//  Top level
//   - FSM, change detect, pending queue, compare, timeout.
// TESTING
//  1 Load {0,6},{0,7},{0,8},{1,0x28}, len=4; start; drive ch0 6,7,8 then ch1 0x28
//    -> o_pass=1, o_matchCount=4, o_fail=0.
//  2 Same table; ch0 goes 6,9
//    -> o_fail=1, FC_MISMATCH, o_failIndex=1, o_failActual={0,9}.
//  3 Table {1,5},{0,3}; ch0 and ch1 change at the same edge to 3 and 5
//    -> WRONG_CH at index 0.
//    Table {0,3},{1,5} -> pass in 2 cycles.
//  4 ch0 changes on 3 consecutive cycles while ch1 stays pending
//    -> FC_OVERRUN only if a ch0 re-change precedes its service; else pass.
//  5 TRACE_TIMEOUT_EN, TIMEOUT_CYC=16; start with no changes
//    -> FC_TIMEOUT exactly 16 cycles after ARM.
//    Macro undefined -> o_busy stays 1.
//  6 Assert resetn mid-RUN after 2 matches
//    -> all outputs 0, IDLE.
//    Also: len=0 start -> o_pass one cycle after ARM.
//    Also: i_tblWe during RUN leaves the table unchanged.

Source files
------------

// File: rtl/io_trace_pkg.sv
// rtl/io_trace_pkg.sv - shared types and helpers for the io_trace_checker block
// Purpose: failure-code and FSM-state enums plus the channel-index width helper.
// Ports: none (package).
package io_trace_pkg;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_MISMATCH = 3'd1,
        FC_WRONG_CH = 3'd2,
        FC_OVERRUN  = 3'd3,
        FC_TIMEOUT  = 3'd4
    } fail_code_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        RUN  = 3'd2,
        PASS = 3'd3,
        FAIL = 3'd4
    } state_e;

    // A single channel still needs one bit of channel field in table entries.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/io_trace_checker_if.sv
// rtl/io_trace_checker_if.sv - control, observation, table-load and status bundle of io_trace_checker
// Purpose: groups every non-clock/reset signal of the checker.
// Ports (signals):
//   i_start, i_obsValid, i_obs, i_tblWe, i_tblAddr, i_tblData, i_tblLen  -> checker
//   o_busy, o_pass, o_fail, o_failCode, o_failIndex, o_failActual, o_matchCount <- checker
// Modports: master (stimulus/host side), slave (checker side).
interface io_trace_checker_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 128
);
    import io_trace_pkg::*;

    localparam int CH_W = ch_w(NUM_CH);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int EW   = CH_W + DATA_W;

    logic                     i_start;
    logic                     i_obsValid;
    logic [NUM_CH*DATA_W-1:0] i_obs;
    logic                     i_tblWe;
    logic [AW-1:0]            i_tblAddr;
    logic [EW-1:0]            i_tblData;
    logic [LW-1:0]            i_tblLen;
    logic                     o_busy;
    logic                     o_pass;
    logic                     o_fail;
    fail_code_e               o_failCode;
    logic [LW-1:0]            o_failIndex;
    logic [EW-1:0]            o_failActual;
    logic [LW-1:0]            o_matchCount;

    modport master (
        output i_start, i_obsValid, i_obs, i_tblWe, i_tblAddr, i_tblData, i_tblLen,
        input  o_busy, o_pass, o_fail, o_failCode, o_failIndex, o_failActual, o_matchCount
    );

    modport slave (
        input  i_start, i_obsValid, i_obs, i_tblWe, i_tblAddr, i_tblData, i_tblLen,
        output o_busy, o_pass, o_fail, o_failCode, o_failIndex, o_failActual, o_matchCount
    );

endinterface

// File: rtl/io_trace_table.sv
// rtl/io_trace_table.sv - expected-trace storage for io_trace_checker
// Purpose: DEPTH x EW RAM, synchronous write, asynchronous read.
// Ports: clk, we, waddr, wdata (write side); raddr -> rdata (combinational read).
module io_trace_table #(
    parameter int DEPTH = 128,
    parameter int EW    = 9
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [EW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [EW-1:0]            rdata
);

    // Contents are deliberately not reset; a trace is always loaded before use.
    logic [EW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/io_trace_checker.sv
// rtl/io_trace_checker.sv - change-detecting trace checker comparing observed channels to a loaded table
// Purpose: detects value changes on NUM_CH observed channels and checks them, in order,
//   against the expected-trace table; reports pass/fail with diagnostics.
// Ports: oszClk (clock), resetn (asynchronous, active-high reset),
//   bus (io_trace_checker_if.slave: start/observation/table-load inputs, status/diagnostic outputs).
// Configuration: TRACE_TIMEOUT_EN enables a TIMEOUT_CYC inter-match watchdog (FC_TIMEOUT).
module io_trace_checker
    import io_trace_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NUM_CH      = 2,
    parameter int DEPTH       = 128,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic          oszClk,
    input  logic          resetn,
    io_trace_checker_if.slave bus
);

    localparam int CH_W = ch_w(NUM_CH);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int EW   = CH_W + DATA_W;
    localparam int OW   = NUM_CH * DATA_W;

    state_e       state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] ptr_q, ptr_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [OW-1:0] prev_q, prev_d;
    logic [OW-1:0] cap_q, cap_d;
    fail_code_e   code_q, code_d;
    logic [LW-1:0] fidx_q, fidx_d;
    logic [EW-1:0] fact_q, fact_d;

`ifdef TRACE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    logic [EW-1:0]     ent;
    logic [CH_W-1:0]   ent_ch;
    logic [DATA_W-1:0] ent_val;
    logic              svc_any;
    logic [CH_W-1:0]   svc_idx;
    logic [DATA_W-1:0] svc_val;
    logic [LW-1:0]     ptr_inc;
    logic              fail_set;
    logic              pass_now;
    logic              match;

    io_trace_table #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_table (
        .clk   (oszClk),
        .we    (bus.i_tblWe && (state_q == IDLE)),
        .waddr (bus.i_tblAddr),
        .wdata (bus.i_tblData),
        .raddr (ptr_q[AW-1:0]),
        .rdata (ent)
    );

    assign ent_ch  = ent[EW-1 -: CH_W];
    assign ent_val = ent[DATA_W-1:0];
    assign ptr_inc = ptr_q + LW'(1);

    // Lowest-index pending channel is serviced; its value is the one captured with pend.
    always_comb begin
        svc_any = 1'b0;
        svc_idx = '0;
        svc_val = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pend_q[c]) begin
                svc_any = 1'b1;
                svc_idx = CH_W'(c);
                svc_val = cap_q[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        ptr_d    = ptr_q;
        pend_d   = pend_q;
        prev_d   = prev_q;
        cap_d    = cap_q;
        code_d   = code_q;
        fidx_d   = fidx_q;
        fact_d   = fact_q;
        fail_set = 1'b0;
        pass_now = 1'b0;
        match    = 1'b0;
`ifdef TRACE_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif

        unique case (state_q)
            IDLE, PASS, FAIL: begin
                if (bus.i_start) begin
                    state_d = ARM;
                    len_d   = bus.i_tblLen;
                    ptr_d   = '0;
                    pend_d  = '0;
                    code_d  = FC_NONE;
                    fidx_d  = '0;
                    fact_d  = '0;
                end
            end

            ARM: begin
                prev_d  = bus.i_obs;
                pend_d  = '0;
                state_d = (len_q == '0) ? PASS : RUN;
`ifdef TRACE_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end

            RUN: begin
                if (svc_any) begin
                    pend_d[svc_idx] = 1'b0;
                    if (ent_ch != svc_idx) begin
                        fail_set = 1'b1;
                        code_d   = FC_WRONG_CH;
                        fidx_d   = ptr_q;
                        fact_d   = {svc_idx, svc_val};
                    end else if (ent_val != svc_val) begin
                        fail_set = 1'b1;
                        code_d   = FC_MISMATCH;
                        fidx_d   = ptr_q;
                        fact_d   = {svc_idx, svc_val};
                    end else begin
                        match = 1'b1;
                        ptr_d = ptr_inc;
                        if (ptr_inc == len_q) begin
                            pass_now = 1'b1;
                        end
                    end
                end

                // A channel may re-change in the very cycle it is serviced: its slot is
                // freed by the service, so the new value simply re-queues.
                if (bus.i_obsValid) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (bus.i_obs[c*DATA_W +: DATA_W] != prev_q[c*DATA_W +: DATA_W]) begin
                            if (pend_q[c] && !(svc_any && (svc_idx == CH_W'(c)))) begin
                                if (!fail_set && !pass_now) begin
                                    fail_set = 1'b1;
                                    code_d   = FC_OVERRUN;
                                    fidx_d   = ptr_q;
                                    fact_d   = {CH_W'(c), bus.i_obs[c*DATA_W +: DATA_W]};
                                end
                            end else begin
                                pend_d[c] = 1'b1;
                                cap_d[c*DATA_W +: DATA_W] = bus.i_obs[c*DATA_W +: DATA_W];
                            end
                        end
                    end
                    prev_d = bus.i_obs;
                end

`ifdef TRACE_TIMEOUT_EN
                if (match) begin
                    tmo_d = '0;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    if (!fail_set && !pass_now) begin
                        fail_set = 1'b1;
                        code_d   = FC_TIMEOUT;
                        fidx_d   = ptr_q;
                        fact_d   = '0;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif

                if (fail_set) begin
                    state_d = FAIL;
                end else if (pass_now) begin
                    state_d = PASS;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge oszClk or posedge resetn) begin
        if (resetn) begin
            state_q <= IDLE;
            len_q   <= '0;
            ptr_q   <= '0;
            pend_q  <= '0;
            prev_q  <= '0;
            cap_q   <= '0;
            code_q  <= FC_NONE;
            fidx_q  <= '0;
            fact_q  <= '0;
`ifdef TRACE_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            prev_q  <= prev_d;
            cap_q   <= cap_d;
            code_q  <= code_d;
            fidx_q  <= fidx_d;
            fact_q  <= fact_d;
`ifdef TRACE_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign bus.o_busy       = (state_q == ARM) || (state_q == RUN);
    assign bus.o_pass       = (state_q == PASS);
    assign bus.o_fail       = (state_q == FAIL);
    assign bus.o_failCode   = code_q;
    assign bus.o_failIndex  = fidx_q;
    assign bus.o_failActual = fact_q;
    assign bus.o_matchCount = ptr_q;

endmodule
